plic_gateway_cc: RTL and testbench

- Per-source interrupt gateway plus claim/complete engine for one PLIC target context.
- Sits on both sides of the arbitration tree:
  - Turns raw level/edge sources into pending bits that feed the tree's `irq_i`.
  - Consumes the tree's winning `irq`/`id` output and drives the hart external-interrupt line.
  - Services claim reads and complete writes from the register interface.
  - Hides arbitration-tree staging latency after each claim.

---
 rtl/plic_gateway_cc.sv | 164 ++++++++++++++++
 tb/tb_plic_gateway_cc.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_gateway_cc.sv
// rtl/plic_gateway_cc.sv - PLIC per-source gateways plus claim/complete engine for one target context
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   src_i, edge_mode_i    raw sources and per-source trigger mode (1 = rising edge)
//   pend_o, in_service_o  gateway state, pend_o feeds the arbitration tree
//   arb_irq_i, arb_id_i   arbitration tree result (threshold already applied)
//   eip_o                 external interrupt pending to the hart
//   claim_req_i           claim read strobe; claim_vld_o/claim_id_o respond one cycle later
//   complete_req_i        complete write strobe with complete_id_i
module plic_gateway_cc #(
    parameter int NUM_IRQ = 512,
    parameter int ID_W    = $clog2(NUM_IRQ),
    parameter int ARB_LAT = 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_IRQ-1:0] src_i,
    input  logic [NUM_IRQ-1:0] edge_mode_i,
    output logic [NUM_IRQ-1:0] pend_o,
    output logic [NUM_IRQ-1:0] in_service_o,
    input  logic               arb_irq_i,
    input  logic [ID_W-1:0]    arb_id_i,
    output logic               eip_o,
    input  logic               claim_req_i,
    output logic               claim_vld_o,
    output logic [ID_W-1:0]    claim_id_o,
    input  logic               complete_req_i,
    input  logic [ID_W-1:0]    complete_id_i
);

    typedef enum logic [1:0] {
        GW_IDLE    = 2'd0,
        GW_PENDING = 2'd1,
        GW_INSERV  = 2'd2
    } gw_state_e;

    gw_state_e          st_q [NUM_IRQ];
    gw_state_e          st_d [NUM_IRQ];
    logic [NUM_IRQ-1:0] hist_q, hist_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [NUM_IRQ-1:0] latch_q, latch_d;
    logic [1:0]         hold_q, hold_d;
    logic               eip_q, eip_d;
    logic               claim_vld_q, claim_vld_d;
    logic [ID_W-1:0]    claim_id_q, claim_id_d;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] claim_sel;
    logic [NUM_IRQ-1:0] comp_sel;
    logic               claim_ok;

    // Claim/complete decode against pre-cycle state. Both selects are one-hot
    // (or empty) and can never hit the same source: one needs PENDING, the
    // other INSERV. ID 0 and out-of-range IDs never match any source.
    always_comb begin
        claim_sel = '0;
        comp_sel  = '0;
        for (int n = 1; n < NUM_IRQ; n++) begin
            claim_sel[n] = (int'(arb_id_i) == n) && (st_q[n] == GW_PENDING);
            comp_sel[n]  = complete_req_i && (int'(complete_id_i) == n) &&
                           (st_q[n] == GW_INSERV);
        end
        claim_ok = claim_req_i && arb_irq_i && (hold_q == 2'd0) && (|claim_sel);
    end

    // Holdoff covers the tree stages that still show the just-claimed ID.
    always_comb begin
        hold_d = hold_q;
        if (claim_ok) begin
            hold_d = 2'(ARB_LAT + 1);
        end else if (hold_q != 2'd0) begin
            hold_d = hold_q - 2'd1;
        end
        eip_d       = arb_irq_i && (hold_d == 2'd0);
        claim_vld_d = claim_req_i;
        claim_id_d  = claim_id_q;
        if (claim_req_i) begin
            claim_id_d = claim_ok ? arb_id_i : '0;
        end
    end

    // Gateways. mode_q tracks edge_mode_i only while IDLE, so a mode change
    // on a busy source waits until the source returns to IDLE.
    always_comb begin
        rise   = src_i & ~hist_q;
        hist_d = src_i;
        for (int n = 0; n < NUM_IRQ; n++) begin
            st_d[n]    = st_q[n];
            mode_d[n]  = mode_q[n];
            latch_d[n] = latch_q[n];
            case (st_q[n])
                GW_IDLE: begin
                    mode_d[n]  = edge_mode_i[n];
                    latch_d[n] = 1'b0;
                    if (edge_mode_i[n] ? rise[n] : src_i[n]) begin
                        st_d[n] = GW_PENDING;
                    end
                end
                GW_PENDING: begin
                    if (mode_q[n] && rise[n]) begin
                        latch_d[n] = 1'b1;
                    end
                    if (claim_ok && claim_sel[n]) begin
                        st_d[n] = GW_INSERV;
                    end
                end
                GW_INSERV: begin
                    if (comp_sel[n]) begin
                        // An edge arriving with the complete finds the latch
                        // full or being consumed, so it is dropped.
                        latch_d[n] = 1'b0;
                        st_d[n]    = (mode_q[n] && latch_q[n]) ? GW_PENDING : GW_IDLE;
                    end else if (mode_q[n] && rise[n]) begin
                        latch_d[n] = 1'b1;
                    end
                end
                default: begin
                    st_d[n] = GW_IDLE;
                end
            endcase
        end
        // Reserved ID 0 never leaves IDLE.
        st_d[0]    = GW_IDLE;
        latch_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int n = 0; n < NUM_IRQ; n++) begin
                st_q[n] <= GW_IDLE;
            end
            hist_q      <= '0;
            mode_q      <= '0;
            latch_q     <= '0;
            hold_q      <= 2'd0;
            eip_q       <= 1'b0;
            claim_vld_q <= 1'b0;
            claim_id_q  <= '0;
        end else begin
            for (int n = 0; n < NUM_IRQ; n++) begin
                st_q[n] <= st_d[n];
            end
            hist_q      <= hist_d;
            mode_q      <= mode_d;
            latch_q     <= latch_d;
            hold_q      <= hold_d;
            eip_q       <= eip_d;
            claim_vld_q <= claim_vld_d;
            claim_id_q  <= claim_id_d;
        end
    end

    always_comb begin
        for (int n = 0; n < NUM_IRQ; n++) begin
            pend_o[n]       = (st_q[n] == GW_PENDING);
            in_service_o[n] = (st_q[n] == GW_INSERV);
        end
        eip_o       = eip_q;
        claim_vld_o = claim_vld_q;
        claim_id_o  = claim_id_q;
    end

endmodule

// File: tb/tb_plic_gateway_cc.sv
// tb/tb_plic_gateway_cc.sv - directed self-checking bench for plic_gateway_cc
module tb_plic_gateway_cc;

    localparam int NUM_IRQ = 32;
    localparam int ID_W    = 6;
    localparam int ARB_LAT = 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_IRQ-1:0] src;
    logic [NUM_IRQ-1:0] edge_mode;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] insv;
    logic               arb_irq;
    logic [ID_W-1:0]    arb_id;
    logic               eip;
    logic               claim_req;
    logic               claim_vld;
    logic [ID_W-1:0]    claim_id;
    logic               complete_req;
    logic [ID_W-1:0]    complete_id;

    logic               arb_irq_m;
    logic [ID_W-1:0]    arb_id_m;
    logic               arb_en;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    plic_gateway_cc #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W), .ARB_LAT(ARB_LAT)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .src_i          (src),
        .edge_mode_i    (edge_mode),
        .pend_o         (pend),
        .in_service_o   (insv),
        .arb_irq_i      (arb_irq),
        .arb_id_i       (arb_id),
        .eip_o          (eip),
        .claim_req_i    (claim_req),
        .claim_vld_o    (claim_vld),
        .claim_id_o     (claim_id),
        .complete_req_i (complete_req),
        .complete_id_i  (complete_id)
    );

    // Arbitration tree model: one register stage, lowest pending ID wins.
    function automatic logic [ID_W-1:0] low_idx(input logic [NUM_IRQ-1:0] p);
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (p[i]) r = ID_W'(i);
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_irq_m <= 1'b0;
            arb_id_m  <= '0;
        end else begin
            arb_irq_m <= |pend;
            arb_id_m  <= low_idx(pend);
        end
    end

    assign arb_irq = arb_irq_m & arb_en;
    assign arb_id  = arb_id_m;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; src = '0; edge_mode = '0; arb_en = 1'b1;
        claim_req = 1'b0; complete_req = 1'b0; complete_id = '0;
        step(); step();
        n_cmp++; if (pend !== 32'h0) begin n_bad++; $display("FAIL rst_pend got=%h exp=%h", pend, 32'h0); end
        n_cmp++; if (insv !== 32'h0) begin n_bad++; $display("FAIL rst_insv got=%h exp=%h", insv, 32'h0); end
        n_cmp++; if ({eip, claim_vld, claim_id} !== 8'h0) begin n_bad++; $display("FAIL rst_outs got=%h exp=0", {eip, claim_vld, claim_id}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_level_claim();
        src[5] = 1'b1; src[6] = 1'b1;
        step();
        n_cmp++; if (pend !== 32'h60) begin n_bad++; $display("FAIL lvl_pend got=%h exp=%h", pend, 32'h60); end
        step(); step();
        n_cmp++; if (eip !== 1'b1) begin n_bad++; $display("FAIL lvl_eip got=%b exp=1", eip); end
        claim_req = 1'b1;
        step();
        n_cmp++; if (claim_vld !== 1'b1 || claim_id !== 6'd5) begin n_bad++; $display("FAIL claim5 got=%b/%0d exp=1/5", claim_vld, claim_id); end
        n_cmp++; if (insv !== 32'h20 || pend !== 32'h40) begin n_bad++; $display("FAIL claim5_state got=%h/%h exp=20/40", insv, pend); end
        n_cmp++; if (eip !== 1'b0) begin n_bad++; $display("FAIL hold_eip1 got=%b exp=0", eip); end
        step();
        n_cmp++; if (claim_vld !== 1'b1 || claim_id !== 6'd0) begin n_bad++; $display("FAIL b2b_claim got=%b/%0d exp=1/0", claim_vld, claim_id); end
        n_cmp++; if (insv !== 32'h20 || pend !== 32'h40) begin n_bad++; $display("FAIL b2b_state got=%h/%h exp=20/40", insv, pend); end
        n_cmp++; if (eip !== 1'b0) begin n_bad++; $display("FAIL hold_eip2 got=%b exp=0", eip); end
        claim_req = 1'b0;
        step();
        n_cmp++; if (claim_vld !== 1'b0 || claim_id !== 6'd0) begin n_bad++; $display("FAIL vld_drop got=%b/%0d exp=0/0", claim_vld, claim_id); end
        n_cmp++; if (eip !== 1'b1) begin n_bad++; $display("FAIL eip_back got=%b exp=1", eip); end
        claim_req = 1'b1;
        step();
        n_cmp++; if (claim_id !== 6'd6 || insv !== 32'h60 || pend !== 32'h0) begin n_bad++; $display("FAIL claim6 got=%0d/%h/%h exp=6/60/0", claim_id, insv, pend); end
        claim_req = 1'b0; src[5] = 1'b0; src[6] = 1'b0;
        complete_req = 1'b1; complete_id = 6'd5;
        step();
        n_cmp++; if (insv !== 32'h40) begin n_bad++; $display("FAIL comp5 got=%h exp=%h", insv, 32'h40); end
        complete_id = 6'd6;
        step();
        complete_req = 1'b0;
        n_cmp++; if (insv !== 32'h0 || pend !== 32'h0) begin n_bad++; $display("FAIL comp6 got=%h/%h exp=0/0", insv, pend); end
    endtask

    task automatic test_no_irq();
        src[2] = 1'b1;
        step();
        arb_en = 1'b0;
        claim_req = 1'b1;
        step();
        claim_req = 1'b0;
        n_cmp++; if (claim_vld !== 1'b1 || claim_id !== 6'd0) begin n_bad++; $display("FAIL noirq_claim got=%b/%0d exp=1/0", claim_vld, claim_id); end
        n_cmp++; if (pend !== 32'h4 || insv !== 32'h0) begin n_bad++; $display("FAIL noirq_state got=%h/%h exp=4/0", pend, insv); end
        arb_en = 1'b1;
        step();
        claim_req = 1'b1;
        step();
        claim_req = 1'b0; src[2] = 1'b0;
        n_cmp++; if (claim_id !== 6'd2 || insv !== 32'h4) begin n_bad++; $display("FAIL claim2 got=%0d/%h exp=2/4", claim_id, insv); end
        complete_req = 1'b1; complete_id = 6'd2;
        step();
        complete_req = 1'b0;
    endtask

    task automatic test_edge();
        edge_mode[9] = 1'b1;
        step();
        src[9] = 1'b1;
        step();
        src[9] = 1'b0;
        n_cmp++; if (pend !== 32'h200) begin n_bad++; $display("FAIL edge_pend got=%h exp=%h", pend, 32'h200); end
        step(); step();
        claim_req = 1'b1;
        step();
        claim_req = 1'b0;
        n_cmp++; if (claim_id !== 6'd9 || insv !== 32'h200) begin n_bad++; $display("FAIL edge_claim got=%0d/%h exp=9/200", claim_id, insv); end
        for (int i = 0; i < 3; i++) begin
            src[9] = 1'b1; step();
            src[9] = 1'b0; step();
        end
        n_cmp++; if (insv !== 32'h200 || pend !== 32'h0) begin n_bad++; $display("FAIL edge_latch got=%h/%h exp=200/0", insv, pend); end
        complete_req = 1'b1; complete_id = 6'd9;
        step();
        n_cmp++; if (pend !== 32'h200 || insv !== 32'h0) begin n_bad++; $display("FAIL edge_repend got=%h/%h exp=200/0", pend, insv); end
        step();
        complete_req = 1'b0;
        n_cmp++; if (pend !== 32'h200 || insv !== 32'h0) begin n_bad++; $display("FAIL edge_comp_pend got=%h/%h exp=200/0", pend, insv); end
        step(); step();
        claim_req = 1'b1;
        step();
        claim_req = 1'b0;
        n_cmp++; if (claim_id !== 6'd9 || insv !== 32'h200) begin n_bad++; $display("FAIL edge_claim2 got=%0d/%h exp=9/200", claim_id, insv); end
        complete_req = 1'b1; complete_id = 6'd9;
        step();
        complete_req = 1'b0;
        n_cmp++; if (pend !== 32'h0 || insv !== 32'h0) begin n_bad++; $display("FAIL edge_idle got=%h/%h exp=0/0", pend, insv); end
    endtask

    task automatic test_bad_complete();
        logic [ID_W-1:0] bad_ids [3];
        bad_ids[0] = 6'd0; bad_ids[1] = 6'd40; bad_ids[2] = 6'd7;
        src[4] = 1'b1;
        step(); step();
        claim_req = 1'b1;
        step();
        claim_req = 1'b0;
        n_cmp++; if (claim_id !== 6'd4 || insv !== 32'h10) begin n_bad++; $display("FAIL claim4 got=%0d/%h exp=4/10", claim_id, insv); end
        for (int i = 0; i < 3; i++) begin
            complete_req = 1'b1; complete_id = bad_ids[i];
            step();
            n_cmp++; if (insv !== 32'h10 || pend !== 32'h0) begin n_bad++; $display("FAIL bad_comp id=%0d got=%h/%h exp=10/0", bad_ids[i], insv, pend); end
        end
        complete_id = 6'd4;
        step();
        complete_req = 1'b0;
        n_cmp++; if (insv !== 32'h0 || pend !== 32'h0) begin n_bad++; $display("FAIL comp4 got=%h/%h exp=0/0", insv, pend); end
        step();
        src[4] = 1'b0;
        n_cmp++; if (pend !== 32'h10) begin n_bad++; $display("FAIL lvl_repend got=%h exp=%h", pend, 32'h10); end
        step();
        claim_req = 1'b1;
        step();
        claim_req = 1'b0;
        complete_req = 1'b1; complete_id = 6'd4;
        step();
        complete_req = 1'b0;
        n_cmp++; if (insv !== 32'h0 || pend !== 32'h0) begin n_bad++; $display("FAIL clean4 got=%h/%h exp=0/0", insv, pend); end
    endtask

    task automatic test_same_cycle();
        src[12] = 1'b1;
        step(); step();
        claim_req = 1'b1;
        step();
        claim_req = 1'b0;
        n_cmp++; if (claim_id !== 6'd12 || insv !== 32'h1000) begin n_bad++; $display("FAIL claim12 got=%0d/%h exp=12/1000", claim_id, insv); end
        src[3] = 1'b1;
        step(); step();
        claim_req = 1'b1; complete_req = 1'b1; complete_id = 6'd12;
        step();
        claim_req = 1'b0; complete_req = 1'b0;
        n_cmp++; if (claim_id !== 6'd3 || insv !== 32'h8 || pend !== 32'h0) begin n_bad++; $display("FAIL same_cyc got=%0d/%h/%h exp=3/8/0", claim_id, insv, pend); end
        step();
        n_cmp++; if (pend !== 32'h1000) begin n_bad++; $display("FAIL same_repend got=%h exp=%h", pend, 32'h1000); end
    endtask

    task automatic test_reset_mid();
        src[3] = 1'b0; src[12] = 1'b0; src[5] = 1'b1;
        step(); step(); step();
        claim_req = 1'b1;
        step();
        claim_req = 1'b0;
        n_cmp++; if (claim_id !== 6'd5 || insv !== 32'h28) begin n_bad++; $display("FAIL claim_pre_rst got=%0d/%h exp=5/28", claim_id, insv); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (pend !== 32'h0 || insv !== 32'h0) begin n_bad++; $display("FAIL midrst_state got=%h/%h exp=0/0", pend, insv); end
        n_cmp++; if ({eip, claim_vld, claim_id} !== 8'h0) begin n_bad++; $display("FAIL midrst_outs got=%h exp=0", {eip, claim_vld, claim_id}); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_cmp++; if (pend !== 32'h0) begin n_bad++; $display("FAIL rst_rel_pend got=%h exp=0", pend); end
        step();
        n_cmp++; if (pend !== 32'h20 || insv !== 32'h0) begin n_bad++; $display("FAIL post_rst got=%h/%h exp=20/0", pend, insv); end
    endtask

    initial begin
        test_reset();
        test_level_claim();
        test_no_irq();
        test_edge();
        test_bad_complete();
        test_same_cycle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
